// File: rtl/jelly_img_alpha_fade_pkg.sv
// ---------------------------------------------------------------------------
// jelly_img_alpha_fade_pkg
//   Shared definitions for the alpha fade controller.
//   fade_state_t : controller FSM encoding
//     ST_IDLE  - no fade in progress, alpha held
//     ST_ARMED - fade accepted, waiting for the next frame start
//     ST_FADE  - stepping alpha every (interval+1) frames
// ---------------------------------------------------------------------------
package jelly_img_alpha_fade_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ARMED = 2'd1,
        ST_FADE  = 2'd2
    } fade_state_t;

endpackage

// File: rtl/jelly_img_alpha_fade_ctl_if.sv
// ---------------------------------------------------------------------------
// jelly_img_alpha_fade_ctl_if
//   Two-source image stream bundle used on both sides of the fade controller.
//   Handshake: valid qualifies a beat; there is no ready. The receiver must
//   accept a beat on every clock where its clock enable is high.
//   Signals: line_first, line_last, pixel_first, pixel_last, de, valid,
//            user [USER_BITS], data0/data1 [COMPONENTS*DATA_WIDTH]
//   Modports: master drives the bundle, slave receives it.
// ---------------------------------------------------------------------------
interface jelly_img_alpha_fade_ctl_if #(
    parameter int USER_BITS  = 1,
    parameter int COMPONENTS = 3,
    parameter int DATA_WIDTH = 8
);
    logic                               line_first;
    logic                               line_last;
    logic                               pixel_first;
    logic                               pixel_last;
    logic                               de;
    logic                               valid;
    logic [USER_BITS-1:0]               user;
    logic [COMPONENTS*DATA_WIDTH-1:0]   data0;
    logic [COMPONENTS*DATA_WIDTH-1:0]   data1;

    modport master (
        output line_first, line_last, pixel_first, pixel_last, de, valid,
        output user, data0, data1
    );

    modport slave (
        input  line_first, line_last, pixel_first, pixel_last, de, valid,
        input  user, data0, data1
    );
endinterface

// File: rtl/jelly_img_alpha_fade_step.sv
// ---------------------------------------------------------------------------
// jelly_img_alpha_fade_step
//   Combinational saturating step of alpha toward target.
//   alpha, target, step -> next_alpha, reached
//   A zero step, or a step at least as large as the remaining distance,
//   lands exactly on target; otherwise alpha moves by step toward target
//   and can never overshoot or wrap.
// ---------------------------------------------------------------------------
module jelly_img_alpha_fade_step #(
    parameter int ALPHA_WIDTH = 8
) (
    input  logic [ALPHA_WIDTH-1:0]  alpha,
    input  logic [ALPHA_WIDTH-1:0]  target,
    input  logic [ALPHA_WIDTH-1:0]  step,
    output logic [ALPHA_WIDTH-1:0]  next_alpha,
    output logic                    reached
);

    logic [ALPHA_WIDTH-1:0] diff;

    always_comb begin
        diff       = (target >= alpha) ? (target - alpha) : (alpha - target);
        next_alpha = target;
        if (step != '0 && diff > step) begin
            // diff > step guarantees the sum/difference stays in range
            next_alpha = (target > alpha) ? (alpha + step) : (alpha - step);
        end
        reached    = (next_alpha == target);
    end

endmodule

// File: rtl/jelly_img_alpha_fade_ctl.sv
// ---------------------------------------------------------------------------
// jelly_img_alpha_fade_ctl
//   Passes a two-source image stream through with one cycle of latency and
//   ramps param_alpha toward a target, one step every (interval+1) frames.
//   Alpha only changes on the edge that registers the frame-start pixel,
//   so it is constant for the whole of every output frame.
//
//   Ports:
//     clk, reset (sync, active-low), cke (0 freezes everything)
//     ctl_start / ctl_abort       : pulses, abort has priority
//     ctl_target/step/interval    : fade parameters
//     status_busy                 : ARMED or FADE
//     status_done                 : one-cycle pulse when alpha lands on target
//     param_alpha                 : alpha for the downstream blend
//     dbg_state                   : current FSM state
//     s_img (slave) / m_img (master) : image stream in / out
//
//   Build option JELLY_IMG_ALPHA_FADE_SHADOW_EN: when defined, target, step
//   and interval are captured at an accepted start; otherwise they are
//   sampled live at every frame start.
// ---------------------------------------------------------------------------
module jelly_img_alpha_fade_ctl
    import jelly_img_alpha_fade_pkg::*;
#(
    parameter int                       COMPONENTS  = 3,
    parameter int                       DATA_WIDTH  = 8,
    parameter int                       ALPHA_WIDTH = 8,
    parameter int                       FRAME_WIDTH = 16,
    parameter int                       USER_WIDTH  = 0,
    parameter int                       USE_VALID   = 0,
    parameter logic [ALPHA_WIDTH-1:0]   INIT_ALPHA  = '0
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        cke,

    input  logic                        ctl_start,
    input  logic                        ctl_abort,
    input  logic [ALPHA_WIDTH-1:0]      ctl_target,
    input  logic [ALPHA_WIDTH-1:0]      ctl_step,
    input  logic [FRAME_WIDTH-1:0]      ctl_interval,

    output logic                        status_busy,
    output logic                        status_done,
    output logic [ALPHA_WIDTH-1:0]      param_alpha,
    output fade_state_t                 dbg_state,

    jelly_img_alpha_fade_ctl_if.slave   s_img,
    jelly_img_alpha_fade_ctl_if.master  m_img
);

    localparam int                      USER_BITS = (USER_WIDTH > 0) ? USER_WIDTH : 1;
    localparam int                      DW        = COMPONENTS * DATA_WIDTH;
    localparam logic [FRAME_WIDTH-1:0]  CNT_ONE   = 1;

    // ---------------- stream pipeline ----------------
    logic                   q_line_first, q_line_last, q_pixel_first, q_pixel_last;
    logic                   q_de, q_valid;
    logic [USER_BITS-1:0]   q_user;
    logic [DW-1:0]          q_data0, q_data1;

    always_ff @(posedge clk) begin
        if (!reset) begin
            q_line_first  <= 1'b0;
            q_line_last   <= 1'b0;
            q_pixel_first <= 1'b0;
            q_pixel_last  <= 1'b0;
            q_de          <= 1'b0;
            q_valid       <= 1'b0;
            q_user        <= '0;
            q_data0       <= '0;
            q_data1       <= '0;
        end else if (cke) begin
            q_line_first  <= s_img.line_first;
            q_line_last   <= s_img.line_last;
            q_pixel_first <= s_img.pixel_first;
            q_pixel_last  <= s_img.pixel_last;
            q_de          <= s_img.de;
            q_valid       <= s_img.valid;
            q_user        <= s_img.user;
            q_data0       <= s_img.data0;
            q_data1       <= s_img.data1;
        end
    end

    assign m_img.line_first  = q_line_first;
    assign m_img.line_last   = q_line_last;
    assign m_img.pixel_first = q_pixel_first;
    assign m_img.pixel_last  = q_pixel_last;
    assign m_img.de          = q_de;
    assign m_img.valid       = q_valid;
    assign m_img.user        = q_user;
    assign m_img.data0       = q_data0;
    assign m_img.data1       = q_data1;

    // ---------------- frame start detect ----------------
    logic valid_eff;
    logic fs;

    assign valid_eff = (USE_VALID != 0) ? s_img.valid : 1'b1;
    assign fs        = cke & valid_eff & s_img.de & s_img.line_first & s_img.pixel_first;

    // ---------------- control state ----------------
    fade_state_t            state;
    logic [FRAME_WIDTH-1:0] frame_cnt;
    logic [ALPHA_WIDTH-1:0] alpha;
    logic                   busy;
    logic                   done;

    logic [ALPHA_WIDTH-1:0] eff_target;
    logic [ALPHA_WIDTH-1:0] eff_step;
    logic [FRAME_WIDTH-1:0] eff_interval;
    logic                   start_accept;

    assign start_accept = ctl_start & ~ctl_abort & (state == ST_IDLE);

`ifdef JELLY_IMG_ALPHA_FADE_SHADOW_EN
    logic [ALPHA_WIDTH-1:0] sh_target;
    logic [ALPHA_WIDTH-1:0] sh_step;
    logic [FRAME_WIDTH-1:0] sh_interval;

    always_ff @(posedge clk) begin
        if (!reset) begin
            sh_target   <= '0;
            sh_step     <= '0;
            sh_interval <= '0;
        end else if (cke && start_accept) begin
            sh_target   <= ctl_target;
            sh_step     <= ctl_step;
            sh_interval <= ctl_interval;
        end
    end

    assign eff_target   = sh_target;
    assign eff_step     = sh_step;
    assign eff_interval = sh_interval;
`else
    assign eff_target   = ctl_target;
    assign eff_step     = ctl_step;
    assign eff_interval = ctl_interval;
`endif

    logic [ALPHA_WIDTH-1:0] next_alpha;
    logic                   reached;

    jelly_img_alpha_fade_step #(
        .ALPHA_WIDTH (ALPHA_WIDTH)
    ) u_step (
        .alpha      (alpha),
        .target     (eff_target),
        .step       (eff_step),
        .next_alpha (next_alpha),
        .reached    (reached)
    );

    // The arming frame start always steps; afterwards only when the
    // frame countdown has expired.
    logic do_step;
    assign do_step = fs & ~ctl_abort &
                     ((state == ST_ARMED) || ((state == ST_FADE) && (frame_cnt == '0)));

    always_ff @(posedge clk) begin
        if (!reset) begin
            state     <= ST_IDLE;
            frame_cnt <= '0;
            alpha     <= INIT_ALPHA;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else if (cke) begin
            done <= 1'b0;
            if (ctl_abort) begin
                state <= ST_IDLE;
                busy  <= 1'b0;
            end else if (do_step) begin
                alpha     <= next_alpha;
                frame_cnt <= eff_interval;
                if (reached) begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b1;
                end else begin
                    state <= ST_FADE;
                    busy  <= 1'b1;
                end
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (start_accept) begin
                            state <= ST_ARMED;
                            busy  <= 1'b1;
                        end
                    end
                    ST_FADE: begin
                        if (fs) begin
                            frame_cnt <= frame_cnt - CNT_ONE;
                        end
                    end
                    ST_ARMED: ;
                    default: begin
                        state <= ST_IDLE;
                        busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign status_busy = busy;
    assign status_done = done;
    assign param_alpha = alpha;
    assign dbg_state   = state;

endmodule

// File: tb/tb_jelly_img_alpha_fade_ctl.sv
module tb_jelly_img_alpha_fade_ctl;
  import jelly_img_alpha_fade_pkg::*;

  localparam int COMPONENTS  = 3;
  localparam int DATA_WIDTH  = 8;
  localparam int ALPHA_WIDTH = 8;
  localparam int FRAME_WIDTH = 16;
  localparam int USER_WIDTH  = 2;
  localparam int USER_BITS   = 2;
  localparam int USE_VALID   = 1;
  localparam int DW          = COMPONENTS * DATA_WIDTH;
`ifdef JELLY_IMG_ALPHA_FADE_SHADOW_EN
  localparam bit SHADOW = 1'b1;
`else
  localparam bit SHADOW = 1'b0;
`endif

  // ---------------- clock / reset ----------------
  logic clk;
  logic reset;
  logic cke;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic                   ctl_start, ctl_abort;
  logic [ALPHA_WIDTH-1:0] ctl_target, ctl_step;
  logic [FRAME_WIDTH-1:0] ctl_interval;
  logic                   status_busy, status_done;
  logic [ALPHA_WIDTH-1:0] param_alpha;
  fade_state_t            dbg_state;

  jelly_img_alpha_fade_ctl_if #(.USER_BITS(USER_BITS), .COMPONENTS(COMPONENTS), .DATA_WIDTH(DATA_WIDTH)) s_if ();
  jelly_img_alpha_fade_ctl_if #(.USER_BITS(USER_BITS), .COMPONENTS(COMPONENTS), .DATA_WIDTH(DATA_WIDTH)) m_if ();

  jelly_img_alpha_fade_ctl #(
    .COMPONENTS  (COMPONENTS),
    .DATA_WIDTH  (DATA_WIDTH),
    .ALPHA_WIDTH (ALPHA_WIDTH),
    .FRAME_WIDTH (FRAME_WIDTH),
    .USER_WIDTH  (USER_WIDTH),
    .USE_VALID   (USE_VALID),
    .INIT_ALPHA  (8'd0)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .cke          (cke),
    .ctl_start    (ctl_start),
    .ctl_abort    (ctl_abort),
    .ctl_target   (ctl_target),
    .ctl_step     (ctl_step),
    .ctl_interval (ctl_interval),
    .status_busy  (status_busy),
    .status_done  (status_done),
    .param_alpha  (param_alpha),
    .dbg_state    (dbg_state),
    .s_img        (s_if),
    .m_img        (m_if)
  );

  // ---------------- scoreboard state ----------------
  int n_vec;
  int n_err;
  int done_seen;

  // stream values driven this cycle
  logic          drv_lf, drv_ll, drv_pf, drv_pl, drv_de, drv_valid;
  logic [1:0]    drv_user;
  logic [DW-1:0] drv_d0, drv_d1;
  logic          drv_start, drv_abort;

  // reference model: fade described as "a job that steps on every
  // (interval+1)-th frame start, counting from the first one after arming"
  logic [55:0]   exp_q[$];
  logic [55:0]   exp_m;
  int            mdl_alpha;
  bit            mdl_armed, mdl_active, mdl_done;
  int            mdl_fs_n;
  int            cap_target, cap_step, cap_interval;

  function automatic int step_to(input int a, input int t, input int s);
    int d;
    d = (t > a) ? (t - a) : (a - t);
    if (s == 0 || d <= s) return t;
    return (t > a) ? (a + s) : (a - s);
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Applies the driven values for one clock, advances the model, checks outputs.
  task automatic cycle();
    bit fs;
    int tgt, stp, itv;
    logic [55:0] obs_m;
    s_if.line_first  = drv_lf;
    s_if.line_last   = drv_ll;
    s_if.pixel_first = drv_pf;
    s_if.pixel_last  = drv_pl;
    s_if.de          = drv_de;
    s_if.valid       = drv_valid;
    s_if.user        = drv_user;
    s_if.data0       = drv_d0;
    s_if.data1       = drv_d1;
    ctl_start        = drv_start;
    ctl_abort        = drv_abort;
    fs = cke && drv_valid && drv_de && drv_lf && drv_pf;
    @(posedge clk);
    if (!reset) begin
      mdl_alpha  = 0;
      mdl_armed  = 0;
      mdl_active = 0;
      mdl_done   = 0;
      exp_q.delete();
      exp_q.push_back(56'd0);
    end else if (cke) begin
      exp_q.delete();
      exp_q.push_back({drv_lf, drv_ll, drv_pf, drv_pl, drv_de, drv_valid, drv_user, drv_d0, drv_d1});
      mdl_done = 0;
      tgt = SHADOW ? cap_target   : int'(ctl_target);
      stp = SHADOW ? cap_step     : int'(ctl_step);
      itv = SHADOW ? cap_interval : int'(ctl_interval);
      if (drv_abort) begin
        mdl_armed  = 0;
        mdl_active = 0;
      end else if (!mdl_armed && !mdl_active) begin
        if (drv_start) begin
          mdl_armed    = 1;
          cap_target   = int'(ctl_target);
          cap_step     = int'(ctl_step);
          cap_interval = int'(ctl_interval);
        end
      end else if (fs) begin
        if (mdl_armed) begin
          mdl_armed  = 0;
          mdl_active = 1;
          mdl_fs_n   = 0;
        end else begin
          mdl_fs_n++;
        end
        if (mdl_fs_n % (itv + 1) == 0) begin
          mdl_alpha = step_to(mdl_alpha, tgt, stp);
          if (mdl_alpha == tgt) begin
            mdl_active = 0;
            mdl_done   = 1;
          end
        end
      end
    end
    #1;
    exp_m = exp_q[0];
    obs_m = {m_if.line_first, m_if.line_last, m_if.pixel_first, m_if.pixel_last,
             m_if.de, m_if.valid, m_if.user, m_if.data0, m_if.data1};
    check("m_img", 64'(obs_m), 64'(exp_m));
    check("alpha", 64'(param_alpha), 64'(mdl_alpha));
    check("busy", 64'(status_busy), 64'(mdl_armed | mdl_active));
    check("done", 64'(status_done), 64'(mdl_done));
    if (status_done) done_seen++;
    drv_start = 1'b0;
    drv_abort = 1'b0;
  endtask

  // ---------------- driver tasks ----------------
  task automatic idle_cycle();
    drv_valid = 1'b0;
    drv_de    = 1'($urandom_range(0, 1));
    drv_lf    = 1'($urandom_range(0, 1));
    drv_pf    = 1'($urandom_range(0, 1));
    drv_ll    = 1'($urandom_range(0, 1));
    drv_pl    = 1'($urandom_range(0, 1));
    drv_user  = 2'($urandom_range(0, 3));
    drv_d0    = DW'($urandom);
    drv_d1    = DW'($urandom);
    cycle();
  endtask

  task automatic pixel(input bit lf, input bit ll, input bit pf, input bit pl);
    drv_valid = 1'b1;
    drv_de    = 1'b1;
    drv_lf    = lf;
    drv_ll    = ll;
    drv_pf    = pf;
    drv_pl    = pl;
    drv_user  = 2'($urandom_range(0, 3));
    drv_d0    = DW'($urandom);
    drv_d1    = DW'($urandom);
    cycle();
  endtask

  task automatic send_frame(input bit gaps);
    for (int l = 0; l < 2; l++) begin
      for (int p = 0; p < 4; p++) begin
        if (gaps && $urandom_range(0, 3) == 0) idle_cycle();
        pixel(l == 0, l == 1, p == 0, p == 3);
      end
    end
  endtask

  task automatic pulse_start();
    drv_start = 1'b1;
    idle_cycle();
  endtask

  task automatic pulse_abort();
    drv_abort = 1'b1;
    idle_cycle();
  endtask

  task automatic set_fade(input int t, input int s, input int i);
    ctl_target   = ALPHA_WIDTH'(t);
    ctl_step     = ALPHA_WIDTH'(s);
    ctl_interval = FRAME_WIDTH'(i);
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    int t1_exp[4];
    int t2_exp[4];
    int iters;
    n_vec = 0; n_err = 0; done_seen = 0;
    t1_exp[0] = 64;  t1_exp[1] = 128; t1_exp[2] = 192; t1_exp[3] = 255;
    t2_exp[0] = 100; t2_exp[1] = 100; t2_exp[2] = 100; t2_exp[3] = 0;
    drv_start = 0; drv_abort = 0;
    cap_target = 0; cap_step = 0; cap_interval = 0; mdl_fs_n = 0;
    set_fade(0, 0, 0);
    cke   = 1'b1;
    reset = 1'b0;
    for (int i = 0; i < 3; i++) idle_cycle();
    check("rst_alpha", 64'(param_alpha), 64'd0);
    check("rst_busy", 64'(status_busy), 64'd0);
    check("rst_state", 64'(dbg_state), 64'(ST_IDLE));
    reset = 1'b1;
    idle_cycle();

    // 1: 0 -> 255 in steps of 64, every frame
    set_fade(255, 64, 0);
    done_seen = 0;
    pulse_start();
    for (int f = 0; f < 4; f++) begin
      send_frame(1'b1);
      check("t1_alpha", 64'(param_alpha), 64'(t1_exp[f]));
    end
    idle_cycle();
    check("t1_done_cnt", 64'(done_seen), 64'd1);
    check("t1_busy", 64'(status_busy), 64'd0);

    // 2: 200 -> 0, step 100, interval 2
    set_fade(200, 0, 0);
    pulse_start();
    send_frame(1'b0);
    check("t2_pre", 64'(param_alpha), 64'd200);
    set_fade(0, 100, 2);
    pulse_start();
    for (int f = 0; f < 4; f++) begin
      send_frame(1'b1);
      check("t2_alpha", 64'(param_alpha), 64'(t2_exp[f]));
    end

    // 3: start in the middle of a frame
    set_fade(60, 30, 0);
    pixel(1, 0, 1, 0);
    pixel(1, 0, 0, 0);
    pulse_start();
    pixel(1, 0, 0, 1);
    for (int p = 0; p < 4; p++) pixel(0, 1, p == 0, p == 3);
    check("t3_hold", 64'(param_alpha), 64'd0);
    check("t3_armed", 64'(status_busy), 64'd1);
    send_frame(1'b0);
    check("t3_first", 64'(param_alpha), 64'd30);
    send_frame(1'b0);
    check("t3_second", 64'(param_alpha), 64'd60);

    // 4: abort at 128; abort+start together
    set_fade(255, 34, 0);
    pulse_start();
    send_frame(1'b0);
    send_frame(1'b0);
    check("t4_mid", 64'(param_alpha), 64'd128);
    done_seen = 0;
    pulse_abort();
    send_frame(1'b1);
    send_frame(1'b1);
    check("t4_alpha", 64'(param_alpha), 64'd128);
    check("t4_busy", 64'(status_busy), 64'd0);
    check("t4_nodone", 64'(done_seen), 64'd0);
    drv_start = 1'b1;
    drv_abort = 1'b1;
    idle_cycle();
    check("t4_both", 64'(status_busy), 64'd0);
    send_frame(1'b0);
    check("t4_after", 64'(param_alpha), 64'd128);

    // 5: cke low across a frame start
    set_fade(0, 28, 0);
    pulse_start();
    send_frame(1'b0);
    check("t5_pre", 64'(param_alpha), 64'd100);
    cke = 1'b0;
    send_frame(1'b0);
    check("t5_frozen", 64'(param_alpha), 64'd100);
    check("t5_busy", 64'(status_busy), 64'd1);
    cke = 1'b1;
    send_frame(1'b0);
    check("t5_resume", 64'(param_alpha), 64'd72);
    pulse_abort();

    // 6: target change mid-fade, then reset mid-fade
    set_fade(255, 10, 0);
    pulse_start();
    send_frame(1'b0);
    send_frame(1'b0);
    check("t6_pre", 64'(param_alpha), 64'd92);
    ctl_target = 8'd50;
    send_frame(1'b0);
    check("t6_follow", 64'(param_alpha), SHADOW ? 64'd102 : 64'd82);
    send_frame(1'b0);
    check("t6_follow2", 64'(param_alpha), SHADOW ? 64'd112 : 64'd72);
    reset = 1'b0;
    idle_cycle();
    idle_cycle();
    check("t6_rst_alpha", 64'(param_alpha), 64'd0);
    check("t6_rst_busy", 64'(status_busy), 64'd0);
    reset = 1'b1;
    idle_cycle();

    // random fades against the model
    iters = 30;
    for (int it = 0; it < iters; it++) begin
      if (!mdl_armed && !mdl_active) ctl_interval = FRAME_WIDTH'($urandom_range(0, 2));
      ctl_target = ALPHA_WIDTH'($urandom_range(0, 255));
      ctl_step   = ALPHA_WIDTH'($urandom_range(0, 80));
      pulse_start();
      for (int f = 0; f < int'($urandom_range(1, 4)); f++) begin
        if ($urandom_range(0, 5) == 0) cke = 1'b0;
        send_frame(1'b1);
        cke = 1'b1;
        if ($urandom_range(0, 7) == 0) pulse_abort();
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
